// File: rtl/fios_res_collector.sv
// fios_res_collector
// Collects the s words of a Montgomery multiplier result (LSW first) together
// with the matching modulus words. Alongside the raw result R, it builds
// D = R - P one word at a time with a rippling borrow. When the last word
// arrives, the final borrow selects which value is presented:
//   - D, the conditionally subtracted result, when R >= P;
//   - R, the raw result, when R < P.
// The chosen value is held with a valid/ready handshake until it is consumed.
module fios_res_collector #(
    parameter int s = 8
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              flush_i,
    input  logic              res_valid_i,
    input  logic [16:0]       res_word_i,
    input  logic [16:0]       p_word_i,
    output logic              in_ready_o,
    output logic [s*17-1:0]   res_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              sub_o,
    output logic              overflow_o
);

    localparam int W        = 17;
    localparam int VW       = s * W;
    localparam int CW       = (s > 2) ? $clog2(s) : 1;
    localparam int LAST_LSB = (s - 1) * W;
    localparam logic [CW-1:0] LAST_CNT = CW'(s - 1);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_borrow;
    logic [VW-1:0] r_r_vec;
    logic [VW-1:0] r_d_vec;
    logic [VW-1:0] r_res;
    logic          r_sub;
    logic          r_ovf;

    logic          w_hold;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_is_last;
    logic          w_borrow_in;
    logic [17:0]   w_diff_full;
    logic [16:0]   w_diff;
    logic          w_borrow_out;
    logic [VW-1:0] w_r_full;
    logic [VW-1:0] w_d_full;

    assign w_hold      = (r_state == ST_HOLD);
    assign w_in_ready  = !w_hold || res_ready_i;
    assign w_accept    = res_valid_i && w_in_ready;
    assign w_is_last   = (r_cnt == LAST_CNT);

    // Word 0 always starts a fresh subtraction, so it ignores any stale borrow.
    assign w_borrow_in = (r_cnt == {CW{1'b0}}) ? 1'b0 : r_borrow;

    // The subtraction is widened by one bit only to capture the borrow-out.
    assign w_diff_full  = {1'b0, res_word_i} - {1'b0, p_word_i} - {17'b0, w_borrow_in};
    assign w_diff       = w_diff_full[16:0];
    assign w_borrow_out = w_diff_full[17];

    // Assemble full R and D with the word arriving now as the top word, so the
    // final value can be captured in the same edge that accepts word s-1.
    always_comb begin
        w_r_full = r_r_vec;
        w_d_full = r_d_vec;
        w_r_full[LAST_LSB +: W] = res_word_i;
        w_d_full[LAST_LSB +: W] = w_diff;
    end

    // Per-word storage of R and D, written at the current word index.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_r_vec <= {VW{1'b0}};
            r_d_vec <= {VW{1'b0}};
        end else if (flush_i) begin
            r_r_vec <= {VW{1'b0}};
            r_d_vec <= {VW{1'b0}};
        end else if (w_accept) begin
            r_r_vec[32'(r_cnt) * 32'd17 +: W] <= res_word_i;
            r_d_vec[32'(r_cnt) * 32'd17 +: W] <= w_diff;
        end else begin
            r_r_vec <= r_r_vec;
            r_d_vec <= r_d_vec;
        end
    end

    // Control state: FSM, word counter, borrow chain, the held output and flags.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= ST_COLLECT;
            r_cnt    <= {CW{1'b0}};
            r_borrow <= 1'b0;
            r_res    <= {VW{1'b0}};
            r_sub    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (flush_i) begin
            r_state  <= ST_COLLECT;
            r_cnt    <= {CW{1'b0}};
            r_borrow <= 1'b0;
            r_res    <= {VW{1'b0}};
            r_sub    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            // A word offered while we cannot take it is lost; remember that.
            if (res_valid_i && !w_in_ready) begin
                r_ovf <= 1'b1;
            end else begin
                r_ovf <= r_ovf;
            end

            if (w_accept && w_is_last) begin
                // Word s-1 is only ever accepted in COLLECT.
                r_state  <= ST_HOLD;
                r_cnt    <= {CW{1'b0}};
                r_borrow <= 1'b0;
                r_sub    <= ~w_borrow_out;
                r_res    <= w_borrow_out ? w_r_full : w_d_full;
            end else if (w_accept) begin
                // An accept while in HOLD is the handshake cycle taking word 0.
                r_state  <= ST_COLLECT;
                r_cnt    <= r_cnt + CW'(1);
                r_borrow <= w_borrow_out;
            end else if (w_hold && res_ready_i) begin
                r_state  <= ST_COLLECT;
            end else begin
                r_state  <= r_state;
            end
        end
    end

    assign in_ready_o  = w_in_ready;
    assign res_valid_o = w_hold;
    assign res_o       = r_res;
    assign sub_o       = r_sub;
    assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_fios_res_collector.sv
// Scoreboard bench for fios_res_collector with s = 2.
// - Stimulus pushes the expected {res, sub} for each result into a queue.
// - A negedge monitor pops and compares an entry on every output handshake.
//   While the output is stalled, the monitor also checks that res_o and sub_o
//   stay stable.
module tb_fios_res_collector;

    localparam int S  = 2;
    localparam int VW = S * 17;

    typedef struct packed {
        logic [VW-1:0] res;
        logic          sub;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0;
    logic          res_valid_i = 1'b0;
    logic [16:0]   res_word_i = 17'd0;
    logic [16:0]   p_word_i = 17'd0;
    logic          res_ready_i = 1'b0;
    logic          in_ready_o;
    logic [VW-1:0] res_o;
    logic          res_valid_o;
    logic          sub_o;
    logic          overflow_o;

    exp_t          q[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          stall_seen = 1'b0;
    logic [VW-1:0] held_res = '0;
    logic          held_sub = 1'b0;

    fios_res_collector #(.s(S)) dut (
        .clock_i     (clk),
        .reset_n_i   (rst_n),
        .flush_i     (flush_i),
        .res_valid_i (res_valid_i),
        .res_word_i  (res_word_i),
        .p_word_i    (p_word_i),
        .in_ready_o  (in_ready_o),
        .res_o       (res_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .sub_o       (sub_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one input beat, let the next rising edge take it, step to edge+1.
    task automatic drive(input logic v, input logic [16:0] r, input logic [16:0] p);
        res_valid_i = v;
        res_word_i  = r;
        p_word_i    = p;
        @(posedge clk);
        #1;
    endtask

    // Queue the expected result, send both words and check the one-cycle latency.
    task automatic send2(input logic [16:0] r1, input logic [16:0] r0,
                         input logic [16:0] p1, input logic [16:0] p0,
                         input logic [VW-1:0] eres, input logic esub, input string nm);
        exp_t e;
        e.res = eres;
        e.sub = esub;
        q.push_back(e);
        drive(1'b1, r0, p0);
        res_valid_i = 1'b1;
        res_word_i  = r1;
        p_word_i    = p1;
        chk({nm, "_valid_before_last"}, 64'(res_valid_o), 64'd0);
        @(posedge clk);
        #1;
        res_valid_i = 1'b0;
        chk({nm, "_valid_after_last"}, 64'(res_valid_o), 64'd1);
    endtask

    // Monitor: compare on each handshake, and check held values while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_seen = 1'b0;
        end else if (res_valid_o) begin
            if (stall_seen) begin
                chk("hold_stable_res", 64'(res_o), 64'(held_res));
                chk("hold_stable_sub", 64'(sub_o), 64'(held_sub));
            end
            if (res_ready_i) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %0h expected no result", res_o);
                end else begin
                    mon_e = q.pop_front();
                    chk("result_res", 64'(res_o), 64'(mon_e.res));
                    chk("result_sub", 64'(sub_o), 64'(mon_e.sub));
                end
                stall_seen = 1'b0;
            end else begin
                stall_seen = 1'b1;
                held_res   = res_o;
                held_sub   = sub_o;
            end
        end else begin
            stall_seen = 1'b0;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, with ready low to show in_ready_o is 1 in reset.
        #1;
        chk("rst_valid",    64'(res_valid_o), 64'd0);
        chk("rst_sub",      64'(sub_o),       64'd0);
        chk("rst_overflow", 64'(overflow_o),  64'd0);
        chk("rst_res",      64'(res_o),       64'd0);
        chk("rst_in_ready", 64'(in_ready_o),  64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_ready_i = 1'b1;

        // Directed vectors; result packed as {word1, word0}.
        send2(17'd0, 17'd7, 17'd0, 17'd5, {17'd0, 17'd2}, 1'b1, "r_gt_p");
        drive(1'b0, 17'd0, 17'd0);
        send2(17'd0, 17'd3, 17'd0, 17'd5, {17'd0, 17'd3}, 1'b0, "r_lt_p");
        drive(1'b0, 17'd0, 17'd0);
        send2(17'd2, 17'd0, 17'd1, 17'h1FFFF, {17'd0, 17'd1}, 1'b1, "borrow_prop");
        drive(1'b0, 17'd0, 17'd0);
        send2(17'd1, 17'h0ABCD, 17'd1, 17'h0ABCD, {17'd0, 17'd0}, 1'b1, "r_eq_p");
        drive(1'b0, 17'd0, 17'd0);

        // Output stalled with words pushing in, then handshake taking word 0.
        res_ready_i = 1'b0;
        send2(17'd5, 17'd9, 17'd3, 17'd4, {17'd2, 17'd5}, 1'b1, "stall");
        begin
            exp_t e2;
            e2.res = {17'd0, 17'd6};
            e2.sub = 1'b1;
            q.push_back(e2);
        end
        for (int i = 0; i < 5; i++) begin
            res_valid_i = 1'b1;
            chk("stall_in_ready", 64'(in_ready_o), 64'd0);
            drive(1'b1, 17'd10, 17'd4);
        end
        chk("stall_overflow", 64'(overflow_o),  64'd1);
        chk("stall_valid",    64'(res_valid_o), 64'd1);
        res_ready_i = 1'b1;
        drive(1'b1, 17'd10, 17'd4);
        res_valid_i = 1'b1;
        res_word_i  = 17'd0;
        p_word_i    = 17'd0;
        chk("handoff_valid_low", 64'(res_valid_o), 64'd0);
        @(posedge clk);
        #1;
        res_valid_i = 1'b0;
        chk("handoff_valid_high", 64'(res_valid_o), 64'd1);
        drive(1'b0, 17'd0, 17'd0);
        chk("overflow_sticky", 64'(overflow_o), 64'd1);

        // Flush after word 0 (which left a borrow), with a word in the flush cycle.
        drive(1'b1, 17'd0, 17'd1);
        flush_i = 1'b1;
        drive(1'b1, 17'h1FFFF, 17'd0);
        flush_i = 1'b0;
        chk("flush_valid",    64'(res_valid_o), 64'd0);
        chk("flush_overflow", 64'(overflow_o),  64'd0);
        chk("flush_sub",      64'(sub_o),       64'd0);
        chk("flush_in_ready", 64'(in_ready_o),  64'd1);
        send2(17'd0, 17'd7, 17'd0, 17'd5, {17'd0, 17'd2}, 1'b1, "post_flush");
        drive(1'b0, 17'd0, 17'd0);

        // Asynchronous reset in the middle of a stalled HOLD.
        res_ready_i = 1'b0;
        send2(17'd1, 17'd3, 17'd0, 17'd1, {17'd1, 17'd2}, 1'b1, "pre_reset");
        drive(1'b1, 17'd4, 17'd4);
        chk("pre_reset_overflow", 64'(overflow_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",    64'(res_valid_o), 64'd0);
        chk("async_rst_overflow", 64'(overflow_o),  64'd0);
        chk("async_rst_sub",      64'(sub_o),       64'd0);
        chk("async_rst_res",      64'(res_o),       64'd0);
        chk("async_rst_in_ready", 64'(in_ready_o),  64'd1);
        void'(q.pop_back());
        res_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_ready_i = 1'b1;
        send2(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFE, {17'd0, 17'd1}, 1'b1, "post_reset");
        drive(1'b0, 17'd0, 17'd0);

        repeat (3) drive(1'b0, 17'd0, 17'd0);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fios_res_collector.md
FIOS_RES_COLLECTOR -- requirements
Module: fios_res_collector

Interface
REQ-001 The module SHALL have parameter s, default 8, meaning the number of 17-bit words per Montgomery result; legal values are s >= 2.
REQ-002 The module SHALL have port clock_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port flush_i, input, 1 bit: synchronous abort of collection and output.
REQ-005 The module SHALL have port res_valid_i, input, 1 bit: a result word and a modulus word are present this cycle.
REQ-006 The module SHALL have port res_word_i, input, 17 bits: one multiplier result word, sent LSW first.
REQ-007 The module SHALL have port p_word_i, input, 17 bits: the modulus word of the same index as res_word_i, supplied by the caller with matching alignment.
REQ-008 The module SHALL have port in_ready_o, output, 1 bit: the word is accepted when res_valid_i and in_ready_o are both high.
REQ-009 The module SHALL have port res_o, output, s*17 bits: the fully reduced result, word k at bits [17k+16:17k].
REQ-010 The module SHALL have port res_valid_o, output, 1 bit: res_o is valid.
REQ-011 The module SHALL have port res_ready_i, input, 1 bit: the downstream consumer accepts res_o.
REQ-012 The module SHALL have port sub_o, output, 1 bit: the modulus was subtracted for the result currently on res_o.
REQ-013 The module SHALL have port overflow_o, output, 1 bit: sticky flag, a word was presented while in_ready_o was low.

Function
REQ-014 States SHALL be COLLECT (word counter 0..s-1) and HOLD (output valid); res_valid_o is 1 exactly in HOLD.
REQ-015 Each accepted word SHALL be stored as R[k] = res_word_i, and D[k] SHALL be stored as the low 17 bits of res_word_i - p_word_i - borrow.
REQ-016 The borrow register SHALL be set from the 17-bit word subtraction, cleared at word 0, and used as the borrow-in for word k+1.
REQ-017 The word counter SHALL increment on each accepted word; gaps in res_valid_i are allowed and SHALL hold all state.
REQ-018 On acceptance of word s-1, the FSM SHALL enter HOLD on the next edge, the counter SHALL wrap to 0, and sub_o SHALL be registered as NOT(final borrow), so that R >= P gives sub_o = 1.
REQ-019 Latency SHALL be: res_valid_o rises one cycle after the cycle in which word s-1 is accepted.
REQ-020 In HOLD, res_o SHALL equal D when sub_o = 1 and R when sub_o = 0, and SHALL be held stable together with sub_o until the handshake completes.
REQ-021 res_valid_o SHALL remain high until res_valid_o and res_ready_i are both high; the FSM SHALL return to COLLECT on the next edge.
REQ-022 in_ready_o SHALL equal (not HOLD) or res_ready_i, combinationally.
REQ-023 In the handshake cycle, word 0 of the next result SHALL be accepted; storage overwrite SHALL not corrupt the res_o value consumed that cycle.
REQ-024 If res_valid_i is high while in_ready_o is low, the word SHALL be dropped, overflow_o SHALL be set, and the state SHALL be unchanged.
REQ-025 overflow_o SHALL clear only on reset or flush_i.
REQ-026 flush_i SHALL have priority over all other inputs: on the next edge the FSM is in COLLECT, the counter is 0, borrow is 0, res_valid_o is 0, sub_o is 0 and overflow_o is 0; a word presented in the flush cycle SHALL be discarded.
REQ-027 No arithmetic result of the block SHALL exceed 17 bits per word; the final borrow is the only carry-out and SHALL not be exported except via sub_o.

Reset
REQ-028 While reset_n_i is low, the outputs SHALL be: res_valid_o 0, sub_o 0, overflow_o 0, res_o all zeros, in_ready_o 1; the FSM SHALL be in COLLECT with counter 0 and borrow 0.
REQ-029 Assertion of reset_n_i during collection or HOLD SHALL discard the partial or held result immediately, without waiting for a clock edge.
REQ-030 Reset SHALL be released synchronously to clock_i by the integrator; the first word SHALL be acceptable on the first edge after release.

Verification (s=2)
REQ-031 R={w1=0,w0=7}, P={0,5} -> res_o word0=2, word1=0, sub_o=1, res_valid_o one cycle after w1.
REQ-032 R={0,3}, P={0,5} -> res_o={0,3}, sub_o=0.
REQ-033 R={2,0x00000}, P={1,0x1FFFF} -> borrow propagates; res_o={0,1}, sub_o=1.
REQ-034 R equals P ({1,0x0ABCD}) -> res_o={0,0}, sub_o=1.
REQ-035 HOLD with res_ready_i=0 for 5 cycles while res_valid_i=1 -> res_o stable, overflow_o=1; then res_ready_i=1 with word0 present -> word0 accepted, next result correct.
REQ-036 flush_i after word 0, and separately reset_n_i low mid-HOLD -> res_valid_o=0 and overflow_o=0; the following two-word result is correct.
